// File: rtl/omsp_spm_seq.sv
// Sequential SPM configuration controller: walks one slot per cycle through a shared read
// port for overlap/lookup checks, then issues one slot write. Option: SPM_SEQ_RANGE_CHECK_EN.
module omsp_spm_seq #(
  parameter int unsigned NB_SPMS = 4,
  parameter int unsigned SLOT_W  = 2
) (
  input  logic              mclk,
  input  logic              puc_rst,
  input  logic              req_valid,
  input  logic              req_op,
  output logic              req_ready,
  input  logic [63:0]       req_bounds,
  input  logic [15:0]       req_pc,
  output logic [SLOT_W-1:0] slot_idx,
  input  logic              slot_en,
  input  logic [63:0]       slot_bounds,
  output logic              slot_wr,
  output logic              slot_wr_en,
  output logic [63:0]       slot_wr_bounds,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [SLOT_W-1:0] result_id
);

  typedef enum logic [1:0] {StIdle, StScan, StCommit, StResp} state_e;

  localparam logic [1:0] StatusOk      = 2'b00;
  localparam logic [1:0] StatusOverlap = 2'b01;
  localparam logic [1:0] StatusNoFree  = 2'b10;
  localparam logic [1:0] StatusInvalid = 2'b11;

  state_e            state;
  logic              op;
  logic [15:0]       pc;
  logic              free_found;
  logic [SLOT_W-1:0] target;

  // Empty ranges are excluded explicitly: the bare interval test would flag [x,x) inside [a,b).
  function automatic logic ovl(input logic [15:0] as, input logic [15:0] ae,
                               input logic [15:0] bs, input logic [15:0] be);
    return (as != ae) && (bs != be) && (as < be) && (bs < ae);
  endfunction

  logic slot_ovl;
  logic pc_hit;
  logic last;

  always_comb begin
    slot_ovl = ovl(slot_wr_bounds[63:48], slot_wr_bounds[47:32],
                   slot_bounds[63:48], slot_bounds[47:32]) ||
               ovl(slot_wr_bounds[63:48], slot_wr_bounds[47:32],
                   slot_bounds[31:16], slot_bounds[15:0]) ||
               ovl(slot_wr_bounds[31:16], slot_wr_bounds[15:0],
                   slot_bounds[63:48], slot_bounds[47:32]) ||
               ovl(slot_wr_bounds[31:16], slot_wr_bounds[15:0],
                   slot_bounds[31:16], slot_bounds[15:0]);
    pc_hit   = (slot_bounds[63:48] <= pc) && (pc < slot_bounds[47:32]);
    last     = (slot_idx == SLOT_W'(NB_SPMS - 1));
  end

`ifdef SPM_SEQ_RANGE_CHECK_EN
  logic req_bad;
  always_comb begin
    req_bad = (req_bounds[63:48] >= req_bounds[47:32]) ||
              (req_bounds[31:16] >= req_bounds[15:0]) ||
              ovl(req_bounds[63:48], req_bounds[47:32], req_bounds[31:16], req_bounds[15:0]);
  end
`endif

  assign req_ready = (state == StIdle) && !puc_rst;
  assign busy      = (state != StIdle);

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state          <= StIdle;
      op             <= 1'b0;
      pc             <= '0;
      free_found     <= 1'b0;
      target         <= '0;
      slot_idx       <= '0;
      slot_wr        <= 1'b0;
      slot_wr_en     <= 1'b0;
      slot_wr_bounds <= '0;
      done           <= 1'b0;
      status         <= StatusOk;
      result_id      <= '0;
    end else begin
      slot_wr <= 1'b0;
      done    <= 1'b0;
      unique case (state)
        StIdle: begin
          if (req_valid) begin
            op             <= req_op;
            pc             <= req_pc;
            slot_wr_bounds <= req_bounds;
            free_found     <= 1'b0;
            slot_idx       <= '0;
`ifdef SPM_SEQ_RANGE_CHECK_EN
            if (!req_op && req_bad) begin
              status <= StatusInvalid;
              done   <= 1'b1;
              state  <= StResp;
            end else begin
              state <= StScan;
            end
`else
            state <= StScan;
`endif
          end
        end

        StScan: begin
          if (!op) begin
            if (slot_en && slot_ovl) begin
              status <= StatusOverlap;
              done   <= 1'b1;
              state  <= StResp;
            end else if (last) begin
              if (free_found || !slot_en) begin
                // Lowest free index wins; the last slot is only the target if nothing earlier was free.
                target     <= free_found ? target : slot_idx;
                slot_idx   <= free_found ? target : slot_idx;
                slot_wr    <= 1'b1;
                slot_wr_en <= 1'b1;
                state      <= StCommit;
              end else begin
                status <= StatusNoFree;
                done   <= 1'b1;
                state  <= StResp;
              end
            end else begin
              if (!slot_en && !free_found) begin
                free_found <= 1'b1;
                target     <= slot_idx;
              end
              slot_idx <= slot_idx + SLOT_W'(1);
            end
          end else begin
            if (slot_en && pc_hit) begin
              target     <= slot_idx;
              slot_wr    <= 1'b1;
              slot_wr_en <= 1'b0;
              state      <= StCommit;
            end else if (last) begin
              status <= StatusInvalid;
              done   <= 1'b1;
              state  <= StResp;
            end else begin
              slot_idx <= slot_idx + SLOT_W'(1);
            end
          end
        end

        StCommit: begin
          status    <= StatusOk;
          result_id <= target;
          done      <= 1'b1;
          state     <= StResp;
        end

        StResp: begin
          state <= StIdle;
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_omsp_spm_seq.sv
// Self-checking bench for omsp_spm_seq: table of requests against a behavioural slot array,
// expected completions tracked in a scoreboard queue, plus reset/busy corner sequences.
module tb_omsp_spm_seq;

  localparam int unsigned N = 4;

  logic        mclk = 1'b0;
  logic        puc_rst;
  logic        req_valid;
  logic        req_op;
  logic        req_ready;
  logic [63:0] req_bounds;
  logic [15:0] req_pc;
  logic [1:0]  slot_idx;
  logic        slot_en;
  logic [63:0] slot_bounds;
  logic        slot_wr;
  logic        slot_wr_en;
  logic [63:0] slot_wr_bounds;
  logic        busy;
  logic        done;
  logic [1:0]  status;
  logic [1:0]  result_id;

  logic [N-1:0]       en_arr;
  logic [N-1:0][63:0] b_arr;

  assign slot_en     = en_arr[slot_idx];
  assign slot_bounds = b_arr[slot_idx];

  always #5 mclk = ~mclk;

  omsp_spm_seq #(.NB_SPMS(N), .SLOT_W(2)) dut (
    .mclk           (mclk),
    .puc_rst        (puc_rst),
    .req_valid      (req_valid),
    .req_op         (req_op),
    .req_ready      (req_ready),
    .req_bounds     (req_bounds),
    .req_pc         (req_pc),
    .slot_idx       (slot_idx),
    .slot_en        (slot_en),
    .slot_bounds    (slot_bounds),
    .slot_wr        (slot_wr),
    .slot_wr_en     (slot_wr_en),
    .slot_wr_bounds (slot_wr_bounds),
    .busy           (busy),
    .done           (done),
    .status         (status),
    .result_id      (result_id)
  );

  typedef struct {
    logic [N-1:0]       en;
    logic [N-1:0][63:0] b;
    logic               op;
    logic [63:0]        rb;
    logic [15:0]        pc;
    logic [1:0]         st;
    logic [1:0]         id;
    int                 done_c;
  } vec_t;

  typedef struct {
    logic [1:0] st;
    logic [1:0] id;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [63:0] bnd(input logic [15:0] a, input logic [15:0] b,
                                      input logic [15:0] c, input logic [15:0] d);
    return {a, b, c, d};
  endfunction

  function automatic vec_t mk(input logic [N-1:0] en, input logic [N-1:0][63:0] b,
                              input logic op, input logic [63:0] rb, input logic [15:0] pc,
                              input logic [1:0] st, input logic [1:0] id, input int done_c);
    vec_t v;
    v.en = en; v.b = b; v.op = op; v.rb = rb; v.pc = pc;
    v.st = st; v.id = id; v.done_c = done_c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_req(input vec_t v, input bit hold);
    int         c;
    int         wr_n;
    int         wr_c;
    logic [1:0] wr_idx;
    logic       wr_en_s;
    logic [63:0] wr_b;
    bit         got;
    exp_t       e;
    en_arr = v.en;
    b_arr  = v.b;
    @(posedge mclk); #1;
    chk("req_ready idle", {63'd0, req_ready}, 64'd1);
    @(negedge mclk);
    req_valid  = 1'b1;
    req_op     = v.op;
    req_bounds = v.rb;
    req_pc     = v.pc;
    q.push_back('{st: v.st, id: v.id, cyc: v.done_c});
    @(posedge mclk); #1;
    if (!hold) req_valid = 1'b0;
    c = 1; wr_n = 0; wr_c = 0; wr_idx = '0; wr_en_s = 1'b0; wr_b = '0; got = 1'b0;
    chk("busy after accept", {63'd0, busy}, 64'd1);
    while (c <= 40 && !got) begin
      if (slot_wr) begin
        wr_n++;
        wr_c    = c;
        wr_idx  = slot_idx;
        wr_en_s = slot_wr_en;
        wr_b    = slot_wr_bounds;
        en_arr[slot_idx] = slot_wr_en;
        b_arr[slot_idx]  = slot_wr_bounds;
      end
      if (done) begin
        got = 1'b1;
        e = q.pop_front();
        chk("done cycle", 64'(c), 64'(e.cyc));
        chk("status", {62'd0, status}, {62'd0, e.st});
        if (e.st == 2'b00) chk("result_id", {62'd0, result_id}, {62'd0, e.id});
        chk("req_ready in resp", {63'd0, req_ready}, 64'd0);
      end else begin
        @(posedge mclk); #1;
        c++;
      end
    end
    req_valid = 1'b0;
    if (!got) begin
      chk("done timeout", 64'd0, 64'd1);
      void'(q.pop_front());
    end
    chk("slot_wr count", 64'(wr_n), (v.st == 2'b00) ? 64'd1 : 64'd0);
    if (v.st == 2'b00) begin
      chk("slot_wr cycle", 64'(wr_c), 64'(v.done_c - 1));
      chk("slot_wr idx", {62'd0, wr_idx}, {62'd0, v.id});
      chk("slot_wr_en", {63'd0, wr_en_s}, {63'd0, !v.op});
      chk("slot_wr_bounds", wr_b, v.rb);
    end
  endtask

  vec_t vecs[12];

  initial begin
    logic [N-1:0][63:0] dj;
    logic [N-1:0][63:0] b0;
    logic [N-1:0][63:0] s2;
    logic [N-1:0][63:0] s3;
    logic [N-1:0][63:0] s1;
    logic [N-1:0][63:0] pcd;
    logic [63:0] inv;

    dj[0] = bnd(16'h1000, 16'h1100, 16'h1200, 16'h1300);
    dj[1] = bnd(16'h2000, 16'h2100, 16'h2200, 16'h2300);
    dj[2] = bnd(16'h3000, 16'h3100, 16'h3200, 16'h3300);
    dj[3] = bnd(16'h4000, 16'h4100, 16'h4200, 16'h4300);
    b0    = dj;
    b0[0] = bnd(16'h8000, 16'h8100, 16'h0200, 16'h0280);
    s2    = dj;
    s2[2] = bnd(16'h9000, 16'h9100, 16'h9200, 16'h9300);
    s3    = dj;
    s3[3] = bnd(16'h6000, 16'h6100, 16'h6200, 16'h6300);
    s1    = dj;
    s1[1] = bnd(16'h1000, 16'h1100, 16'h2000, 16'h2100);
    pcd   = dj;
    pcd[1] = bnd(16'h7000, 16'h7100, 16'h7200, 16'h7300);
    inv   = bnd(16'h8100, 16'h8000, 16'h0200, 16'h0280);

    vecs[0]  = mk(4'b0000, b0, 1'b0, bnd(16'h8000, 16'h8100, 16'h0200, 16'h0280), 16'h0,
                  2'b00, 2'd0, 6);
    vecs[1]  = mk(4'b0001, b0, 1'b0, bnd(16'h80F0, 16'h8200, 16'h0300, 16'h0380), 16'h0,
                  2'b01, 2'd0, 2);
    vecs[2]  = mk(4'b1111, dj, 1'b0, bnd(16'h5000, 16'h5100, 16'h5200, 16'h5300), 16'h0,
                  2'b10, 2'd0, 5);
    vecs[3]  = mk(4'b0100, s2, 1'b1, 64'h0, 16'h9050, 2'b00, 2'd2, 5);
    vecs[4]  = mk(4'b0100, s2, 1'b1, 64'h0, 16'h9100, 2'b11, 2'd0, 5);
    vecs[5]  = mk(4'b1101, b0, 1'b0, bnd(16'hA000, 16'hA100, 16'hA200, 16'hA300), 16'h0,
                  2'b00, 2'd1, 6);
    vecs[6]  = mk(4'b0111, dj, 1'b0, bnd(16'hA000, 16'hA100, 16'hA200, 16'hA300), 16'h0,
                  2'b00, 2'd3, 6);
    vecs[7]  = mk(4'b1111, s3, 1'b0, bnd(16'h7000, 16'h7100, 16'h6250, 16'h6400), 16'h0,
                  2'b01, 2'd0, 5);
    vecs[8]  = mk(4'b0001, b0, 1'b1, 64'h0, 16'h8000, 2'b00, 2'd0, 3);
    vecs[9]  = mk(4'b1101, pcd, 1'b1, 64'h0, 16'h7050, 2'b11, 2'd0, 5);
    vecs[10] = mk(4'b0010, s1, 1'b0, bnd(16'h20F0, 16'h2200, 16'h3000, 16'h3100), 16'h0,
                  2'b01, 2'd0, 3);
`ifdef SPM_SEQ_RANGE_CHECK_EN
    vecs[11] = mk(4'b0000, dj, 1'b0, inv, 16'h0, 2'b11, 2'd0, 1);
`else
    vecs[11] = mk(4'b0000, dj, 1'b0, inv, 16'h0, 2'b00, 2'd0, 6);
`endif

    en_arr = '0; b_arr = '0;
    puc_rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_bounds = '0; req_pc = '0;
    repeat (2) @(posedge mclk);
    #1;
    chk("rst req_ready", {63'd0, req_ready}, 64'd0);
    chk("rst busy", {63'd0, busy}, 64'd0);
    chk("rst done", {63'd0, done}, 64'd0);
    chk("rst status", {62'd0, status}, 64'd0);
    chk("rst result_id", {62'd0, result_id}, 64'd0);
    chk("rst slot_idx", {62'd0, slot_idx}, 64'd0);
    chk("rst slot_wr", {63'd0, slot_wr}, 64'd0);
    chk("rst slot_wr_en", {63'd0, slot_wr_en}, 64'd0);
    chk("rst slot_wr_bounds", slot_wr_bounds, 64'd0);
    @(negedge mclk);
    puc_rst = 1'b0;

    for (int i = 0; i < 12; i++) run_req(vecs[i], 1'b0);

    // req_valid held high through the whole transaction must not start a second one.
    run_req(vecs[0], 1'b1);
    @(posedge mclk); #1;
    chk("no re-accept busy", {63'd0, busy}, 64'd0);

    // Reset while scanning discards the request.
    en_arr = '0;
    @(negedge mclk);
    req_valid  = 1'b1;
    req_op     = 1'b0;
    req_bounds = bnd(16'h8000, 16'h8100, 16'h0200, 16'h0280);
    @(posedge mclk); #1;
    req_valid = 1'b0;
    @(posedge mclk); #1;
    chk("busy in scan", {63'd0, busy}, 64'd1);
    @(negedge mclk);
    puc_rst = 1'b1;
    @(posedge mclk); #1;
    chk("mid rst busy", {63'd0, busy}, 64'd0);
    chk("mid rst done", {63'd0, done}, 64'd0);
    chk("mid rst slot_wr", {63'd0, slot_wr}, 64'd0);
    @(negedge mclk);
    puc_rst = 1'b0;
    repeat (6) begin
      @(posedge mclk); #1;
      chk("post rst quiet", {62'd0, done, slot_wr}, 64'd0);
    end
    run_req(vecs[0], 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
